// File: rtl/paint_pkg.sv
// Shared constants and types for the paint-layer grid interface.
// The default tile geometry is 8x8 pixels of 24 bits each.
package paint_pkg;

    localparam int DATA_W   = 24;
    localparam int GRID     = 8;
    localparam int TILE_PIX = GRID * GRID;

    typedef logic [DATA_W-1:0]            pixel_t;
    typedef logic [$clog2(TILE_PIX)-1:0]  tile_idx_t;

    // Bit offset of element (r,c) inside a flattened tile bus.
    function automatic int elem_lsb(input int r, input int c);
        return (r * GRID + c) * DATA_W;
    endfunction

endpackage

// File: rtl/grid_region_loader_tile_bank.sv
// One GRID x GRID pixel register array with a single write port.
// The whole array is exposed as one flattened read bus.
module tile_bank #(
    parameter int DATA_W = paint_pkg::DATA_W,
    parameter int GRID   = paint_pkg::GRID
) (
    input  logic                               i_clk,
    input  logic                               rst_n,
    input  logic                               wr_en,
    input  logic [$clog2(GRID*GRID)-1:0]       wr_idx,
    input  logic [DATA_W-1:0]                  wr_data,
    output logic [GRID*GRID*DATA_W-1:0]        rd_tile
);

    logic [GRID*GRID*DATA_W-1:0] mem;

    // Contents are cleared on reset so an idle loader presents an all-zero tile.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (wr_en) begin
            mem[wr_idx*DATA_W +: DATA_W] <= wr_data;
        end
    end

    assign rd_tile = mem;

endmodule

// File: rtl/grid_region_loader.sv
// Assembles a row-major pixel stream into GRID x GRID tiles using two
// ping-pong banks, handing each finished tile off under valid/ready.
module grid_region_loader #(
    parameter int DATA_W = paint_pkg::DATA_W,
    parameter int GRID   = paint_pkg::GRID
) (
    input  logic                          i_clk,
    input  logic                          rst_n,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_valid,
    input  logic                          i_sof,
    output logic                          o_ready,
    output logic [GRID*GRID*DATA_W-1:0]   o_tile,
    output logic                          o_tile_valid,
    input  logic                          i_tile_ready,
    output logic [15:0]                   o_tile_cnt,
    output logic                          o_sync_err
);

    localparam int TPIX   = GRID * GRID;
    localparam int IDX_W  = $clog2(TPIX);
    localparam int TILE_W = TPIX * DATA_W;

    logic [1:0]        full;
    logic              wsel;
    logic              rsel;
    logic [IDX_W-1:0]  widx;
    logic [15:0]       tile_cnt;
    logic              sync_err;

    logic              accept;
    logic              handoff;
    logic              realign;
    logic              complete;
    logic [IDX_W-1:0]  wr_idx;
    logic [1:0]        bank_we;
    logic [TILE_W-1:0] tile0;
    logic [TILE_W-1:0] tile1;

    // Ready comes purely from registered flags, keeping input timing clean.
    assign o_ready  = ~full[wsel];
    assign accept   = i_valid & o_ready;
    assign handoff  = full[rsel] & i_tile_ready;

    // A start-of-tile marker mid-fill restarts the tile at element 0.
    assign realign  = accept & i_sof & (widx != '0);
    assign wr_idx   = realign ? '0 : widx;
    assign complete = accept & ~realign & (widx == IDX_W'(TPIX - 1));

    assign bank_we[0] = accept & ~wsel;
    assign bank_we[1] = accept &  wsel;

    tile_bank #(
        .DATA_W (DATA_W),
        .GRID   (GRID)
    ) u_bank0 (
        .i_clk   (i_clk),
        .rst_n   (rst_n),
        .wr_en   (bank_we[0]),
        .wr_idx  (wr_idx),
        .wr_data (i_data),
        .rd_tile (tile0)
    );

    tile_bank #(
        .DATA_W (DATA_W),
        .GRID   (GRID)
    ) u_bank1 (
        .i_clk   (i_clk),
        .rst_n   (rst_n),
        .wr_en   (bank_we[1]),
        .wr_idx  (wr_idx),
        .wr_data (i_data),
        .rd_tile (tile1)
    );

    // Completion and handoff never hit the same bank: the write bank is empty
    // when it completes, while the read bank must be full to hand off.
    always_ff @(posedge i_clk or negedge rst_n) begin
        if (!rst_n) begin
            full     <= 2'b00;
            wsel     <= 1'b0;
            rsel     <= 1'b0;
            widx     <= '0;
            tile_cnt <= '0;
            sync_err <= 1'b0;
        end else begin
            if (handoff) begin
                full[rsel] <= 1'b0;
                rsel       <= ~rsel;
                tile_cnt   <= tile_cnt + 16'd1;
            end
            if (accept) begin
                if (realign) begin
                    widx     <= IDX_W'(1);
                    sync_err <= 1'b1;
                end else if (complete) begin
                    full[wsel] <= 1'b1;
                    wsel       <= ~wsel;
                    widx       <= '0;
                end else begin
                    widx <= widx + IDX_W'(1);
                end
            end
        end
    end

    assign o_tile_valid = full[rsel];
    assign o_tile       = rsel ? tile1 : tile0;
    assign o_tile_cnt   = tile_cnt;
    assign o_sync_err   = sync_err;

endmodule
